// File: rtl/fft_input_loader.sv
// Ping-pong input buffer for a radix-4 FFT: stores real samples digit-reversed, emits groups of four.
// Optional macro ADC_OFFSET_BINARY_EN: treat sample_in as offset-binary and convert to two's complement.
module fft_input_loader #(
  parameter int WIDTH  = 24,
  parameter int POINTS = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH/2-1:0] sample_in,
  input  logic               sample_valid,
  output logic [WIDTH-1:0]   a,
  output logic [WIDTH-1:0]   b,
  output logic [WIDTH-1:0]   c,
  output logic [WIDTH-1:0]   d,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               frame_first,
  output logic               frame_last,
  output logic               overflow
);

  localparam int HALF_WIDTH = WIDTH / 2;
  localparam int AW         = $clog2(POINTS);
  localparam int KW         = AW - 2;
  localparam int DIGITS     = AW / 2;
  localparam logic [AW-1:0] N_LAST = AW'(POINTS - 1);
  localparam logic [KW-1:0] K_LAST = KW'(POINTS / 4 - 1);

  typedef enum logic {W_FILL, W_FULL} wstate_t;
  typedef enum logic {R_IDLE, R_BUSY} rstate_t;

  wstate_t         wstate, wstate_nxt;
  rstate_t         rstate, rstate_nxt;
  logic [AW-1:0]   wcnt, wcnt_nxt;
  logic [KW-1:0]   k, k_nxt;
  logic            wbank, wbank_nxt;
  logic            rbank;

  logic [WIDTH-1:0]      mem [2*POINTS];
  logic [HALF_WIDTH-1:0] sample_conv;

  logic wr_en, wr_last, xfer, xfer_last;

  function automatic logic [AW-1:0] digit_rev4(input logic [AW-1:0] n);
    logic [AW-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < DIGITS; i++)
      r[2*i +: 2] = n[AW-2-2*i +: 2];
    return r;
  endfunction

`ifdef ADC_OFFSET_BINARY_EN
  assign sample_conv = {~sample_in[HALF_WIDTH-1], sample_in[HALF_WIDTH-2:0]};
`else
  assign sample_conv = sample_in;
`endif

  assign rbank     = ~wbank;
  assign wr_en     = sample_valid && (wstate == W_FILL);
  assign wr_last   = wr_en && (wcnt == N_LAST);
  assign xfer      = (rstate == R_BUSY) && out_ready;
  assign xfer_last = xfer && (k == K_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wstate <= W_FILL;
      rstate <= R_IDLE;
      wcnt   <= '0;
      k      <= '0;
      wbank  <= 1'b0;
    end else begin
      wstate <= wstate_nxt;
      rstate <= rstate_nxt;
      wcnt   <= wcnt_nxt;
      k      <= k_nxt;
      wbank  <= wbank_nxt;
    end
  end

  // A swap happens at most once per cycle: either the read side finishes
  // (with a full or just-completed write bank) or the write side completes
  // while the read side is idle; the two cannot coincide.
  always_comb begin
    wstate_nxt = wstate;
    rstate_nxt = rstate;
    wcnt_nxt   = wcnt;
    k_nxt      = k;
    wbank_nxt  = wbank;

    if (wr_en) wcnt_nxt = wcnt + 1'b1;
    if (xfer)  k_nxt    = k + 1'b1;

    if (xfer_last) begin
      if (wstate == W_FULL || wr_last) begin
        wbank_nxt  = ~wbank;
        wstate_nxt = W_FILL;
      end else begin
        rstate_nxt = R_IDLE;
      end
    end

    if (wr_last) begin
      if (rstate == R_IDLE) begin
        wbank_nxt  = ~wbank;
        rstate_nxt = R_BUSY;
        k_nxt      = '0;
      end else if (!xfer_last) begin
        wstate_nxt = W_FULL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && wr_en)
      mem[{wbank, digit_rev4(wcnt)}] <= {sample_conv, {HALF_WIDTH{1'b0}}};
  end

  assign out_valid   = (rstate == R_BUSY);
  assign frame_first = out_valid && (k == '0);
  assign frame_last  = out_valid && (k == K_LAST);
  assign overflow    = sample_valid && (wstate == W_FULL);

  assign a = out_valid ? mem[{rbank, k, 2'd0}] : '0;
  assign b = out_valid ? mem[{rbank, k, 2'd1}] : '0;
  assign c = out_valid ? mem[{rbank, k, 2'd2}] : '0;
  assign d = out_valid ? mem[{rbank, k, 2'd3}] : '0;

endmodule

// File: tb/tb_fft_input_loader.sv
// Scoreboard bench for fft_input_loader (POINTS=16, WIDTH=24); honours ADC_OFFSET_BINARY_EN.
module tb_fft_input_loader;

  logic        clk;
  logic        rst_n;
  logic [11:0] sample_in;
  logic        sample_valid;
  logic [23:0] a, b, c, d;
  logic        out_valid, out_ready, frame_first, frame_last, overflow;

  fft_input_loader #(.WIDTH(24), .POINTS(16)) dut (
    .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_valid(sample_valid),
    .a(a), .b(b), .c(c), .d(d), .out_valid(out_valid), .out_ready(out_ready),
    .frame_first(frame_first), .frame_last(frame_last), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef logic [11:0] frame_t [16];
  typedef struct {
    logic [23:0] a, b, c, d;
    logic        first, last;
  } grp_t;

  grp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   ovf_cnt = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] cv(input logic [11:0] s);
`ifdef ADC_OFFSET_BINARY_EN
    return s ^ 12'h800;
`else
    return s;
`endif
  endfunction

  // Sample n lands at address 4*(n%4) + n/4, so group k holds samples k, 4+k, 8+k, 12+k.
  task automatic push_frame(input frame_t s);
    grp_t g;
    for (int k = 0; k < 4; k++) begin
      g.a = {cv(s[k]),      12'h000};
      g.b = {cv(s[4 + k]),  12'h000};
      g.c = {cv(s[8 + k]),  12'h000};
      g.d = {cv(s[12 + k]), 12'h000};
      g.first = (k == 0);
      g.last  = (k == 3);
      exp_q.push_back(g);
    end
  endtask

  task automatic send_sample(input logic [11:0] v);
    sample_in = v;
    sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
  endtask

  task automatic send_frame(input frame_t s);
    for (int i = 0; i < 16; i++) send_sample(s[i]);
    push_frame(s);
  endtask

  task automatic wait_drain(input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk(nm, exp_q.size(), 0);
  endtask

  task automatic chk_reset_outs(input string nm);
    chk(nm, {out_valid, frame_first, frame_last, overflow, a, b, c, d}, '0);
  endtask

  // Monitor: zero outputs when idle, stability under stall, and scoreboard pops.
  logic            stall_prev = 1'b0;
  logic [97:0]     held;
  grp_t            g;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (overflow) ovf_cnt++;
      if (out_valid === 1'b0) chk("idle outputs zero", {a, b, c, d}, '0);
      if (stall_prev && out_valid)
        chk("hold under stall", {a, b, c, d, frame_first, frame_last}, held);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious group", 1, 0);
        end else begin
          g = exp_q.pop_front();
          chk("group a", a, g.a);
          chk("group b", b, g.b);
          chk("group c", c, g.c);
          chk("group d", d, g.d);
          chk("frame_first", frame_first, g.first);
          chk("frame_last", frame_last, g.last);
        end
      end
      stall_prev = out_valid && !out_ready;
      held = {a, b, c, d, frame_first, frame_last};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end, time %0t", $time);
    $fatal(1);
  end

  frame_t f;
  int     ovf0;
  int     n;

  initial begin
    rst_n = 1'b0; sample_valid = 1'b0; sample_in = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outs("reset state");
    rst_n = 1'b1;

    // Frame 1..16 streamed with the consumer always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) f[i] = 12'(i + 1);
    for (int i = 0; i < 15; i++) send_sample(f[i]);
    chk("valid before last sample", out_valid, 0);
    send_sample(f[15]);
    chk("valid one cycle after last", out_valid, 1);
    push_frame(f);
    wait_drain("drain frame 1");

    // Stall five cycles on group 1.
    out_ready = 1'b0;
    send_frame(f);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("stall group 1 first", frame_first, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("stall keeps valid", out_valid, 1);
    out_ready = 1'b1;
    wait_drain("drain stalled frame");

    // Two frames pile up, a third-frame sample is dropped, then back-to-back drain.
    out_ready = 1'b0;
    ovf0 = ovf_cnt;
    for (int i = 0; i < 16; i++) f[i] = 12'(100 + i);
    send_frame(f);
    for (int i = 0; i < 16; i++) f[i] = 12'(200 + i);
    send_frame(f);
    chk("no overflow while filling", ovf_cnt - ovf0, 0);
    send_sample(12'h3e7);
    chk("one overflow pulse", ovf_cnt - ovf0, 1);
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      chk("continuous valid", out_valid, 1);
      @(posedge clk); #1;
      n++;
    end
    chk("drain back-to-back", exp_q.size(), 0);
    chk("valid drops after drain", out_valid, 0);

    // Last sample of the next frame coincides with the last group transfer.
    out_ready = 1'b0;
    ovf0 = ovf_cnt;
    for (int i = 0; i < 16; i++) f[i] = 12'(300 + i);
    send_frame(f);
    for (int i = 0; i < 16; i++) f[i] = 12'(400 + i);
    for (int i = 0; i < 12; i++) send_sample(f[i]);
    for (int i = 12; i < 16; i++) begin
      sample_in = f[i];
      sample_valid = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
    end
    sample_valid = 1'b0;
    push_frame(f);
    chk("coincident swap valid", out_valid, 1);
    chk("coincident swap first", frame_first, 1);
    chk("coincident no overflow", ovf_cnt - ovf0, 0);
    wait_drain("drain coincident");

    // Reset mid-frame discards partial data.
    for (int i = 0; i < 7; i++) send_sample(12'(500 + i));
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_reset_outs("mid-frame reset state");
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) f[i] = 12'(i + 1);
    send_frame(f);
    wait_drain("drain after reset");

    // Sign boundaries and offset-binary conversion.
    out_ready = 1'b0;
    f = '{12'h800, 12'h7ff, 12'hfff, 12'h001, 12'h000, 12'h801, 12'h7fe, 12'h123,
          12'h400, 12'hc00, 12'h0ff, 12'hf00, 12'h555, 12'haaa, 12'h080, 12'hf80};
    send_frame(f);
`ifdef ADC_OFFSET_BINARY_EN
    chk("offset-binary 800 -> 0", a, 24'h000000);
    chk("offset-binary 000 -> -2048", b, 24'h800000);
`else
    chk("twos 800 stored raw", a, 24'h800000);
    chk("twos 000 stored raw", b, 24'h000000);
`endif
    out_ready = 1'b1;
    wait_drain("drain boundary frame");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
